// File: rtl/bcd_time_loader.sv
// bcd_time_loader: collects a 14-digit BCD timestamp (Y3..Y0 M1 M0 D1 D0 h1 h0
// m1 m0 s1 s0) one digit per handshake, converts each field to binary, checks
// the ranges and then either strobes the new time onto the field outputs or
// flags the frame as rejected.
// Optional: define BCD_TIME_LOADER_DOM_CHECK_EN to also reject days beyond the
// length of the month (leap years included).
module bcd_time_loader #(
   parameter int NUM_DIGITS = 14,
   parameter int RST_YEAR   = 2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        digit_valid,
   input  logic [3:0]  digit_in,
   output logic        digit_ready,
   input  logic        abort,
   output logic [5:0]  sec,
   output logic [5:0]  min,
   output logic [4:0]  hour,
   output logic [4:0]  day,
   output logic [3:0]  mon,
   output logic [13:0] year,
   output logic        set_valid,
   output logic        set_err,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_CHECK} state_t;

   state_t      state_reg;
   logic [3:0]  count_reg;
   logic        bad_digit_reg;
   logic [13:0] year_acc_reg;
   logic [3:0]  mon_acc_reg;
   logic [4:0]  day_acc_reg;
   logic [4:0]  hour_acc_reg;
   logic [5:0]  min_acc_reg;
   logic [5:0]  sec_acc_reg;

   logic        digit_take;
   logic        last_digit;
   logic        frame_ok;
   logic [13:0] mul_src;
   logic [13:0] mul_res;

   // acc*10 + digit using shifts, always evaluated at 14 bits
   function automatic logic [13:0] mul10_add(input logic [13:0] acc, input logic [3:0] d);
      return (acc << 3) + (acc << 1) + {10'd0, d};
   endfunction

   assign digit_take = digit_valid && digit_ready;
   assign last_digit = (count_reg == 4'(NUM_DIGITS - 1));

   // Pick the accumulator the current digit belongs to and form its next value
   always_comb begin
      mul_src = 14'd0;
      case (count_reg)
         4'd0, 4'd1, 4'd2, 4'd3: mul_src = year_acc_reg;
         4'd4, 4'd5:             mul_src = {10'd0, mon_acc_reg};
         4'd6, 4'd7:             mul_src = {9'd0, day_acc_reg};
         4'd8, 4'd9:             mul_src = {9'd0, hour_acc_reg};
         4'd10, 4'd11:           mul_src = {8'd0, min_acc_reg};
         default:                mul_src = {8'd0, sec_acc_reg};
      endcase
      mul_res = mul10_add(mul_src, digit_in);
   end

`ifdef BCD_TIME_LOADER_DOM_CHECK_EN
   logic       leap;
   logic [4:0] dim;
`endif

   // Range check of the assembled frame, evaluated while in CHECK
   always_comb begin
      frame_ok = !bad_digit_reg &&
                 (sec_acc_reg <= 6'd59) && (min_acc_reg <= 6'd59) &&
                 (hour_acc_reg <= 5'd23) &&
                 (day_acc_reg >= 5'd1) && (day_acc_reg <= 5'd31) &&
                 (mon_acc_reg >= 4'd1) && (mon_acc_reg <= 4'd12);
`ifdef BCD_TIME_LOADER_DOM_CHECK_EN
      leap = ((year_acc_reg % 14'd4) == 14'd0 && (year_acc_reg % 14'd100) != 14'd0) ||
             ((year_acc_reg % 14'd400) == 14'd0);
      case (mon_acc_reg)
         4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
         4'd2:                    dim = leap ? 5'd29 : 5'd28;
         default:                 dim = 5'd31;
      endcase
      frame_ok = frame_ok && (day_acc_reg <= dim);
`endif
   end

   // Frame FSM: collect digits, check once, commit or reject, with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         count_reg     <= 4'd0;
         bad_digit_reg <= 1'b0;
         year_acc_reg  <= 14'd0;
         mon_acc_reg   <= 4'd0;
         day_acc_reg   <= 5'd0;
         hour_acc_reg  <= 5'd0;
         min_acc_reg   <= 6'd0;
         sec_acc_reg   <= 6'd0;
         sec           <= 6'd0;
         min           <= 6'd0;
         hour          <= 5'd0;
         day           <= 5'd1;
         mon           <= 4'd1;
         year          <= 14'(RST_YEAR);
         set_valid     <= 1'b0;
         set_err       <= 1'b0;
         busy          <= 1'b0;
         digit_ready   <= 1'b1;
      end else begin
         set_valid <= 1'b0;
         set_err   <= 1'b0;
         // abort wins over a digit presented in the same cycle; IDLE ignores it
         if (state_reg != ST_IDLE && abort) begin
            state_reg     <= ST_IDLE;
            busy          <= 1'b0;
            digit_ready   <= 1'b1;
         end else begin
            case (state_reg)
               ST_IDLE, ST_COLLECT: begin
                  if (digit_take) begin
                     count_reg <= count_reg + 4'd1;
                     busy      <= 1'b1;
                     if (digit_in > 4'd9)
                        bad_digit_reg <= 1'b1;
                     case (count_reg)
                        4'd0, 4'd1, 4'd2, 4'd3: year_acc_reg <= mul_res;
                        4'd4, 4'd5:             mon_acc_reg  <= mul_res[3:0];
                        4'd6, 4'd7:             day_acc_reg  <= mul_res[4:0];
                        4'd8, 4'd9:             hour_acc_reg <= mul_res[4:0];
                        4'd10, 4'd11:           min_acc_reg  <= mul_res[5:0];
                        default:                sec_acc_reg  <= mul_res[5:0];
                     endcase
                     if (last_digit) begin
                        state_reg   <= ST_CHECK;
                        digit_ready <= 1'b0;
                     end else begin
                        state_reg   <= ST_COLLECT;
                     end
                  end
               end
               default: begin
                  if (frame_ok) begin
                     year      <= year_acc_reg;
                     mon       <= mon_acc_reg;
                     day       <= day_acc_reg;
                     hour      <= hour_acc_reg;
                     min       <= min_acc_reg;
                     sec       <= sec_acc_reg;
                     set_valid <= 1'b1;
                  end else begin
                     set_err   <= 1'b1;
                  end
                  state_reg   <= ST_IDLE;
                  busy        <= 1'b0;
                  digit_ready <= 1'b1;
               end
            endcase
         end
         // Every return to IDLE starts the next frame from a clean slate
         if ((state_reg != ST_IDLE && abort) || (state_reg == ST_CHECK)) begin
            count_reg     <= 4'd0;
            bad_digit_reg <= 1'b0;
            year_acc_reg  <= 14'd0;
            mon_acc_reg   <= 4'd0;
            day_acc_reg   <= 5'd0;
            hour_acc_reg  <= 5'd0;
            min_acc_reg   <= 6'd0;
            sec_acc_reg   <= 6'd0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_time_loader.sv
// Testbench for bcd_time_loader: frames are driven digit by digit, the
// expected outcome of each frame is queued at its last handshake and compared
// when the set_valid/set_err pulse appears.
module tb_bcd_time_loader;

   logic        clk;
   logic        rst_n;
   logic        digit_valid;
   logic [3:0]  digit_in;
   logic        digit_ready;
   logic        abort;
   logic [5:0]  sec;
   logic [5:0]  min;
   logic [4:0]  hour;
   logic [4:0]  day;
   logic [3:0]  mon;
   logic [13:0] year;
   logic        set_valid;
   logic        set_err;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int last_hs = 0;

   typedef struct {
      bit          ok;
      int          cyc;
      logic [39:0] fields;
   } exp_t;

   exp_t        sb_q[$];
   logic [39:0] model_fields;

   bcd_time_loader #(.NUM_DIGITS(14), .RST_YEAR(2000)) dut (
      .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(digit_in),
      .digit_ready(digit_ready), .abort(abort), .sec(sec), .min(min), .hour(hour),
      .day(day), .mon(mon), .year(year), .set_valid(set_valid), .set_err(set_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   function automatic logic [39:0] pack_fields(input int y, input int mo, input int d,
                                               input int h, input int mi, input int s);
      return {14'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
   endfunction

   // Compare every output pulse against the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && (set_valid || set_err)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("pulse_kind", {63'd0, set_valid}, {63'd0, e.ok});
            check("pulse_excl", {63'd0, set_valid & set_err}, 64'd0);
            check("latency", 64'(cyc), 64'(e.cyc));
            check("fields", {24'd0, year, mon, day, hour, min, sec}, {24'd0, e.fields});
            check("busy_fall", {63'd0, busy}, 64'd0);
         end
      end
   end

   task automatic send_digit(input logic [3:0] d);
      int guard;
      guard = 0;
      @(negedge clk);
      digit_valid = 1'b1;
      digit_in    = d;
      while (!digit_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         check("ready_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
      last_hs = cyc;
   endtask

   task automatic send_frame(input int y, input int mo, input int d, input int h,
                             input int mi, input int s, input int bad_pos, input bit gaps);
      logic [3:0] dg[14];
      int  vals[6];
      int  mov, dv, hv, miv, sv, dim;
      bit  ok, leap;
      exp_t e;
      vals = '{y, mo, d, h, mi, s};
      dg[0] = 4'((y / 1000) % 10);
      dg[1] = 4'((y / 100) % 10);
      dg[2] = 4'((y / 10) % 10);
      dg[3] = 4'(y % 10);
      for (int f = 1; f < 6; f++) begin
         dg[2 + 2*f] = 4'((vals[f] / 10) % 10);
         dg[3 + 2*f] = 4'(vals[f] % 10);
      end
      if (bad_pos >= 0) dg[bad_pos] = 4'hB;
      for (int i = 0; i < 14; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               digit_valid = 1'b0;
            end
         end
         send_digit(dg[i]);
      end
      check("ready_low_in_check", {63'd0, digit_ready}, 64'd0);
      mov = (mo % 100) & 15;
      dv  = (d % 100) & 31;
      hv  = (h % 100) & 31;
      miv = (mi % 100) & 63;
      sv  = (s % 100) & 63;
      ok = (bad_pos < 0) && sv <= 59 && miv <= 59 && hv <= 23 &&
           dv >= 1 && dv <= 31 && mov >= 1 && mov <= 12;
`ifdef BCD_TIME_LOADER_DOM_CHECK_EN
      leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (mov == 4 || mov == 6 || mov == 9 || mov == 11) dim = 30;
      else if (mov == 2) dim = leap ? 29 : 28;
      else dim = 31;
      ok = ok && (dv <= dim);
`else
      leap = 1'b0;
      dim  = 31;
`endif
      if (ok) model_fields = pack_fields(y, mov, dv, hv, miv, sv);
      e.ok     = ok;
      e.cyc    = last_hs + 1;
      e.fields = model_fields;
      sb_q.push_back(e);
      @(negedge clk);
      digit_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("sb_drain", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      digit_valid = 1'b0;
      digit_in = 4'd0;
      abort = 1'b0;
      model_fields = pack_fields(2000, 1, 1, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_fields", {24'd0, year, mon, day, hour, min, sec}, {24'd0, model_fields});
      check("reset_ready", {63'd0, digit_ready}, 64'd1);
      check("reset_busy", {63'd0, busy}, 64'd0);

      // Main frame, back-to-back digits
      send_frame(2024, 3, 15, 13, 45, 9, -1, 1'b0);
      drain();
      // Out-of-range hour, bad digit, zero month
      send_frame(2030, 6, 10, 24, 0, 0, -1, 1'b0);
      send_frame(2030, 6, 10, 12, 0, 0, 6, 1'b0);
      send_frame(2030, 0, 10, 12, 0, 0, -1, 1'b0);
      drain();

      // Abort after 7 digits, with a digit presented alongside abort
      for (int i = 0; i < 7; i++) send_digit(4'd1);
      @(negedge clk);
      check("busy_mid_frame", {63'd0, busy}, 64'd1);
      digit_valid = 1'b1;
      digit_in    = 4'd2;
      abort       = 1'b1;
      @(negedge clk);
      abort       = 1'b0;
      digit_valid = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      send_frame(1999, 12, 31, 23, 59, 59, -1, 1'b0);
      drain();

      // Asynchronous reset mid-frame
      for (int i = 0; i < 5; i++) send_digit(4'd3);
      @(negedge clk);
      digit_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_fields = pack_fields(2000, 1, 1, 0, 0, 0);
      check("midreset_fields", {24'd0, year, mon, day, hour, min, sec}, {24'd0, model_fields});
      check("midreset_ready", {63'd0, digit_ready}, 64'd1);
      check("midreset_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Same frame as the first, now with random gaps
      send_frame(2024, 3, 15, 13, 45, 9, -1, 1'b1);
      drain();

      // Month-length cases
      send_frame(2023, 2, 29, 1, 2, 3, -1, 1'b0);
`ifdef BCD_TIME_LOADER_DOM_CHECK_EN
      send_frame(2024, 2, 29, 4, 5, 6, -1, 1'b0);
      send_frame(2100, 2, 29, 7, 8, 9, -1, 1'b0);
      send_frame(2000, 2, 29, 10, 11, 12, -1, 1'b0);
      send_frame(2024, 4, 31, 13, 14, 15, -1, 1'b0);
`endif
      drain();

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bcd_time_loader.md
Name: bcd_time_loader

Overview:
- Reverse direction of the binary-to-BCD display conversion. Accepts a timestamp entered one BCD digit per handshake, for example from a keypad or UART front end.
- Converts the digits to the binary field widths used by the clock core: sec/min 6b, hour/day 5b, mon 4b, year 14b.
- Range-checks the timestamp, then either issues a one-cycle load strobe to the clock/calendar counters or flags an error.

Parameters:
- NUM_DIGITS, 14, digits per frame. Fixed order Y3 Y2 Y1 Y0 M1 M0 D1 D0 h1 h0 m1 m0 s1 s0 (most significant first). Only the value 14 is supported.
- RST_YEAR, 2000, reset/default year value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- digit_valid  in  1  digit_in is presented this cycle
- digit_in  in  4  BCD digit
- digit_ready  out  1  loader can accept a digit
- abort  in  1  discard the partial frame and return to IDLE
- sec  out  6  binary seconds
- min  out  6  binary minutes
- hour  out  5  binary hours
- day  out  5  binary day of month
- mon  out  4  binary month
- year  out  14  binary year
- set_valid  out  1  one-cycle pulse: new time loaded on the field outputs
- set_err  out  1  one-cycle pulse: frame rejected
- busy  out  1  a frame is in progress (COLLECT or CHECK)

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: sec=0, min=0, hour=0, day=1, mon=1, year=RST_YEAR. set_valid=0, set_err=0, busy=0, digit_ready=1. FSM in IDLE, digit count 0, all accumulators 0, error flag clear.
- Handshake: a digit is accepted on a clk edge when digit_valid && digit_ready. digit_ready=1 in IDLE and COLLECT, 0 in CHECK.
- IDLE:
  - A digit is accepted -> count=1, move to COLLECT, busy=1.
  - That digit is routed to the year accumulator.
- COLLECT:
  - Each accepted digit updates its field accumulator: acc <= acc*10 + digit. Implement *10 as (acc<<3)+(acc<<1), computed at 14 bits, then truncated to the field width.
  - Routing by count: 0-3 year, 4-5 mon, 6-7 day, 8-9 hour, 10-11 min, 12-13 sec.
  - digit_in > 9 sets a sticky bad_digit flag. The digit is still counted; collection continues.
  - When the 14th digit is accepted -> CHECK.
- CHECK, one cycle:
  - Valid when: no bad_digit, sec<=59, min<=59, hour<=23, 1<=day<=31, 1<=mon<=12. Year 0-9999 is always in range.
  - Valid -> field outputs updated from the accumulators on the exit edge, and set_valid=1 for exactly the following cycle.
  - Invalid -> outputs unchanged, set_err=1 for one cycle.
  - Either way -> IDLE, accumulators and flags cleared, busy=0.
- Latency: set_valid/set_err is asserted in the second cycle after the 14th digit's handshake edge.
- abort:
  - Ignored in IDLE.
  - Active in COLLECT or CHECK -> IDLE next edge, no pulse, outputs unchanged.
  - abort has priority over a simultaneous digit handshake; that digit is dropped.
- Field outputs change only on a valid commit. They hold their values across rejected and aborted frames.
- rst_n asserted mid-frame: immediate return to the reset state, no pulse.
- digit_valid while digit_ready=0 (CHECK): the digit is not accepted. The source must hold it.

Optional Feature:
- Macro: BCD_TIME_LOADER_DOM_CHECK_EN.
- Defined:
  - CHECK also rejects a day beyond the month length: 30 for months 4, 6, 9, 11; 28 for Feb, or 29 when the year is a leap year.
  - Leap year: (year%4==0 && year%100!=0) || year%400==0. Evaluated in the CHECK cycle; latency unchanged.
- Undefined: only the 1..31 day check applies.

Test Plan:
- Digits 2,0,2,4,0,3,1,5,1,3,4,5,0,9, back-to-back -> set_valid pulse two cycles after the last handshake; year=2024, mon=3, day=15, hour=13, min=45, sec=9. busy falls with the pulse.
- Frame with hour digits 2,4 -> set_err pulse, no set_valid; outputs keep the previous values.
- Frame containing digit_in=4'hB at position 6 -> all 14 digits accepted, then set_err. Separately, mon=00 -> set_err.
- abort after 7 digits, then a full valid frame 1999-12-31 23:59:59 -> only one set_valid, with year=1999, mon=12, day=31, hour=23, min=59, sec=59.
- rst_n pulsed low mid-frame -> outputs immediately 0/0/0/1/1/2000, digit_ready=1. Also random digit_valid gaps -> same result as the back-to-back case.
- With BCD_TIME_LOADER_DOM_CHECK_EN: 2023-02-29 -> set_err; 2024-02-29 -> set_valid; 2100-02-29 -> set_err; 2000-02-29 -> set_valid; 2024-04-31 -> set_err. Without the macro: 2023-02-29 -> set_valid.
